regfile_sched: RTL

Scoreboard and write-port scheduler for the 32-entry register bank in the decode stage. It holds decoded instructions in decode until their operands and destination are free of pending writes. It also arbitrates the ALU and load (LMD) writeback sources onto the bank's single write port. It sits between decode, the two writeback sources and the register bank.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sched_if.sv | 48 ++++
 rtl/wb_rr_arbiter.sv | 48 ++++
 rtl/regfile_sched.sv | 108 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register scoreboard and
// writeback scheduler.
package regfile_pkg;

  localparam int unsigned RF_NREG = 32;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned RF_DW   = 32;

  // Writeback arbitration policies
  localparam int unsigned ARB_RR        = 0;
  localparam int unsigned ARB_FIXED_MEM = 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_sched_if.sv
// Decode issue, ALU/MEM writeback and register-bank write signals of regfile_sched.
interface regfile_sched_if #(
  parameter int unsigned AW = regfile_pkg::RF_AW,
  parameter int unsigned DW = regfile_pkg::RF_DW
);

  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] id_rd;
  logic          id_wr_en;
  logic          id_ready;

  logic          alu_wb_valid;
  logic [AW-1:0] alu_wb_rd;
  logic [DW-1:0] alu_wb_data;
  logic          alu_wb_ready;

  logic          mem_wb_valid;
  logic [AW-1:0] mem_wb_rd;
  logic [DW-1:0] mem_wb_data;
  logic          mem_wb_ready;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wr_en,
    input  id_ready,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  mem_wb_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wr_en,
    output id_ready,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output mem_wb_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-requester writeback arbiter: round-robin or fixed MEM-over-ALU priority.
module wb_rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  src_e last_q, last_d;

  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_mem_o = 1'b0;
    if (req_alu_i && req_mem_i) begin
      if (ARB_MODE == ARB_FIXED_MEM || last_q == SRC_ALU) begin
        gnt_mem_o = 1'b1;
      end else begin
        gnt_alu_o = 1'b1;
      end
    end else begin
      gnt_alu_o = req_alu_i;
      gnt_mem_o = req_mem_i;
    end

    last_d = last_q;
    if (gnt_alu_o) begin
      last_d = SRC_ALU;
    end else if (gnt_mem_o) begin
      last_d = SRC_MEM;
    end
  end

  // Reset to "MEM granted last" so the first contested grant goes to ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_sched.sv
// Decode-stage scoreboard (RAW/WAW interlock) and single-port writeback scheduler
// for the 32-entry register bank.
module regfile_sched
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_sched_if.slave   bus,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_spurious
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;

  logic          gnt_alu, gnt_mem, wb_fire, id_ready, issue;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  wb_rr_arbiter #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_alu_i(bus.alu_wb_valid),
    .req_mem_i(bus.mem_wb_valid),
    .gnt_alu_o(gnt_alu),
    .gnt_mem_o(gnt_mem)
  );

  assign id_ready = !(busy_q[bus.id_rs1] || busy_q[bus.id_rs2] ||
                      (bus.id_wr_en && busy_q[bus.id_rd]));
  assign issue    = bus.id_valid && id_ready;
  assign wb_fire  = gnt_alu || gnt_mem;
  assign wb_rd    = gnt_mem ? bus.mem_wb_rd : bus.alu_wb_rd;
  assign wb_data  = gnt_mem ? bus.mem_wb_data : bus.alu_wb_data;

  always_comb begin
    // Writes to r0 still handshake but never reach the bank
    rf_we_d    = wb_fire && (wb_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_fire) begin
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end

    // Busy clears as the bank is written, one cycle after the handshake
    busy_d = busy_q;
    err_d  = err_q;
    if (rf_we_q) begin
      if (busy_q[rf_waddr_q]) begin
        busy_d[rf_waddr_q] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (issue && bus.id_wr_en && (bus.id_rd != '0)) begin
      busy_d[bus.id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    stall_d = stall_q;
    if (bus.id_valid && !id_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.alu_wb_ready = gnt_alu;
  assign bus.mem_wb_ready = gnt_mem;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign busy_vec         = busy_q;
  assign stall_cycles     = stall_q;
  assign err_spurious     = err_q;

endmodule
